// File: rtl/placar_colisao_pkg.sv
// placar_colisao_pkg: shared game types, constants and scoring/collision helpers
package placar_colisao_pkg;
   typedef enum logic [1:0] {JOGANDO, PAUSADO, PERDEU} estado_t;
   localparam logic [6:0] SEG_APAGADO = 7'h7F;
   localparam int LARG_BCD = 4;
   // 4-digit BCD increment that saturates at 9999
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic c;
      r = v;
      c = 1'b1;
      if (v == 16'h9999) return v;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*LARG_BCD +: LARG_BCD] == 4'd9) r[i*LARG_BCD +: LARG_BCD] = 4'd0;
            else begin
               r[i*LARG_BCD +: LARG_BCD] = r[i*LARG_BCD +: LARG_BCD] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction
   // ball treated as square [c-r, c+r]; only additions so nothing underflows
   function automatic logic sobrepoe(input logic [9:0] xb, yb, rb, xr, yr, wr, hr);
      logic [10:0] xb1, yb1, rb1, xr1, yr1, wr1, hr1;
      xb1 = {1'b0, xb};
      yb1 = {1'b0, yb};
      rb1 = {1'b0, rb};
      xr1 = {1'b0, xr};
      yr1 = {1'b0, yr};
      wr1 = {1'b0, wr};
      hr1 = {1'b0, hr};
      return (rb != 10'd0) && (wr != 10'd0) && (hr != 10'd0) &&
             (xb1 + rb1 >= xr1) && (xb1 < xr1 + wr1 + rb1) &&
             (yb1 + rb1 >= yr1) && (yb1 < yr1 + hr1 + rb1);
   endfunction
endpackage

// File: rtl/placar_colisao_hex7seg.sv
// hex7seg: BCD digit to active-low 7-segment pattern
// ports: digito (4-bit value) -> seg (gfedcba, active-low); non-decimal values blank
module hex7seg
   import placar_colisao_pkg::*;
(
   input  logic [3:0] digito,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_APAGADO;
      case (digito)
         4'd0: seg = 7'h40;
         4'd1: seg = 7'h79;
         4'd2: seg = 7'h24;
         4'd3: seg = 7'h30;
         4'd4: seg = 7'h19;
         4'd5: seg = 7'h12;
         4'd6: seg = 7'h02;
         4'd7: seg = 7'h78;
         4'd8: seg = 7'h00;
         4'd9: seg = 7'h10;
         default: seg = SEG_APAGADO;
      endcase
   end
endmodule

// File: rtl/placar_colisao.sv
// placar_colisao: collision detection, score/lives keeping and 7-segment display
// ports: CLOCK_50, reset (sync, active-low), pausa, reinicio; ally/enemy ball
// centre+radius, ship/enemy rectangles; perdeu, hit pulses, pontos (BCD), vidas,
// HEX0..HEX5 (HEX3..HEX0 score, HEX4 blank, HEX5 lives)
module placar_colisao
   import placar_colisao_pkg::*;
#(
   parameter int VIDAS_INICIAIS = 3,
   parameter int INVULN_CICLOS  = 25_000_000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        pausa,
   input  logic        reinicio,
   input  logic [9:0]  x_bola_aliada,
   input  logic [9:0]  y_bola_aliada,
   input  logic [9:0]  raio_bola_aliada,
   input  logic [9:0]  x_bola_inimiga,
   input  logic [9:0]  y_bola_inimiga,
   input  logic [9:0]  raio_bola_inimiga,
   input  logic [9:0]  x_nave,
   input  logic [9:0]  y_nave,
   input  logic [9:0]  largura_nave,
   input  logic [9:0]  altura_nave,
   input  logic [9:0]  x_inimigo,
   input  logic [9:0]  y_inimigo,
   input  logic [9:0]  largura_inimigo,
   input  logic [9:0]  altura_inimigo,
   output logic        perdeu,
   output logic        acerto_aliado,
   output logic        acerto_inimigo,
   output logic [15:0] pontos,
   output logic [1:0]  vidas,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5
);
   localparam int LC = $clog2(INVULN_CICLOS + 1);
   localparam int CW = LC < 1 ? 1 : LC;
   localparam logic [CW-1:0] IMUNE_CARGA = CW'(INVULN_CICLOS);
   localparam logic [1:0] VIDAS0 = 2'(VIDAS_INICIAIS);
   estado_t estado, prox;
   logic [CW-1:0] imune;
   logic ov_a, ov_i, ov_a_q, ov_i_q, evt_a, evt_i, jogo, conta_i, morre;
   logic [LARG_BCD-1:0] dig [6];
   logic [6:0] seg [6];
   assign ov_a = sobrepoe(x_bola_aliada, y_bola_aliada, raio_bola_aliada,
                          x_inimigo, y_inimigo, largura_inimigo, altura_inimigo);
   assign ov_i = sobrepoe(x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
                          x_nave, y_nave, largura_nave, altura_nave);
   // events use the live overlap against last cycle's, so the pulse lands one cycle later
   assign evt_a   = ov_a & ~ov_a_q;
   assign evt_i   = ov_i & ~ov_i_q;
   assign jogo    = estado == JOGANDO;
   assign conta_i = jogo & evt_i & (imune == '0);
   assign morre   = conta_i & (vidas == 2'd1);
   assign perdeu  = estado == PERDEU;
   always_comb begin
      prox = estado == JOGANDO ? (morre ? PERDEU : pausa ? PAUSADO : JOGANDO) :
             estado == PAUSADO ? (pausa ? PAUSADO : JOGANDO) :
             reinicio ? JOGANDO : PERDEU;
   end
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         estado         <= JOGANDO;
         pontos         <= '0;
         vidas          <= VIDAS0;
         imune          <= '0;
         ov_a_q         <= 1'b0;
         ov_i_q         <= 1'b0;
         acerto_aliado  <= 1'b0;
         acerto_inimigo <= 1'b0;
      end else begin
         estado         <= prox;
         ov_a_q         <= ov_a;
         ov_i_q         <= ov_i;
         acerto_aliado  <= jogo & evt_a;
         acerto_inimigo <= conta_i;
         if (perdeu && reinicio) begin
            pontos <= '0;
            vidas  <= VIDAS0;
            imune  <= '0;
         end else if (jogo) begin
            if (evt_a) pontos <= bcd_inc(pontos);
            if (conta_i) begin
               vidas <= vidas - 2'd1;
               imune <= IMUNE_CARGA;
            end else if (imune != '0) imune <= imune - 1'b1;
         end
      end
   end
   // decoder inputs are forced to the reset values so the registered HEX match at reset
   always_comb begin
      for (int k = 0; k < 4; k++) dig[k] = reset ? pontos[k*LARG_BCD +: LARG_BCD] : '0;
      dig[4] = 4'hF;
      dig[5] = reset ? {2'b00, vidas} : 4'(VIDAS_INICIAIS);
   end
   for (genvar i = 0; i < 6; i++) begin : g_hex
      hex7seg u_hex (.digito(dig[i]), .seg(seg[i]));
   end
   always_ff @(posedge CLOCK_50) begin
      HEX0 <= seg[0];
      HEX1 <= seg[1];
      HEX2 <= seg[2];
      HEX3 <= seg[3];
      HEX4 <= seg[4];
      HEX5 <= seg[5];
   end
endmodule

// File: tb/tb_placar_colisao.sv
// tb_placar_colisao: directed self-checking bench for placar_colisao
module tb_placar_colisao;
   logic CLOCK_50 = 1'b0, reset = 1'b0, pausa = 1'b0, reinicio = 1'b0;
   logic [9:0] x_bola_aliada = 10'd50, y_bola_aliada = 10'd100, raio_bola_aliada = 10'd5;
   logic [9:0] x_bola_inimiga = 10'd310, y_bola_inimiga = 10'd310, raio_bola_inimiga = 10'd0;
   logic [9:0] x_nave = 10'd300, y_nave = 10'd300, largura_nave = 10'd20, altura_nave = 10'd20;
   logic [9:0] x_inimigo = 10'd102, y_inimigo = 10'd90, largura_inimigo = 10'd20, altura_inimigo = 10'd20;
   logic perdeu, acerto_aliado, acerto_inimigo;
   logic [15:0] pontos;
   logic [1:0] vidas;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   int total = 0, bad = 0, n;
   placar_colisao #(.VIDAS_INICIAIS(3), .INVULN_CICLOS(8)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reinicio(reinicio),
      .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada), .raio_bola_aliada(raio_bola_aliada),
      .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga), .raio_bola_inimiga(raio_bola_inimiga),
      .x_nave(x_nave), .y_nave(y_nave), .largura_nave(largura_nave), .altura_nave(altura_nave),
      .x_inimigo(x_inimigo), .y_inimigo(y_inimigo), .largura_inimigo(largura_inimigo), .altura_inimigo(altura_inimigo),
      .perdeu(perdeu), .acerto_aliado(acerto_aliado), .acerto_inimigo(acerto_inimigo),
      .pontos(pontos), .vidas(vidas),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
   );
   always #10 CLOCK_50 = ~CLOCK_50;
   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask
   task automatic confere(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [15:0] to_bcd(input int v);
      return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
   endfunction
   initial begin
      tick();
      tick();
      confere("rst_pontos", pontos, 16'h0000);
      confere("rst_vidas", {14'd0, vidas}, 16'd3);
      confere("rst_perdeu", {15'd0, perdeu}, 16'd0);
      confere("rst_pulsos", {14'd0, acerto_aliado, acerto_inimigo}, 16'd0);
      confere("rst_hex0", {9'd0, HEX0}, 16'h40);
      confere("rst_hex4", {9'd0, HEX4}, 16'h7F);
      confere("rst_hex5", {9'd0, HEX5}, 16'h30);
      reset = 1'b1;
      tick();
      confere("longe_pulso", {15'd0, acerto_aliado}, 16'd0);
      x_bola_aliada = 10'd100;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (acerto_aliado) n++;
      end
      confere("ali_npulsos", 16'(n), 16'd1);
      confere("ali_pontos", pontos, 16'h0001);
      confere("ali_hex0", {9'd0, HEX0}, 16'h79);
      x_bola_aliada = 10'd50;
      x_inimigo = 10'd100;
      tick();
      x_bola_aliada = 10'd95;
      tick();
      confere("toque_pulso", {15'd0, acerto_aliado}, 16'd1);
      confere("toque_pontos", pontos, 16'h0002);
      x_bola_aliada = 10'd94;
      tick();
      confere("x94_pulso", {15'd0, acerto_aliado}, 16'd0);
      tick();
      confere("x94_pontos", pontos, 16'h0002);
      x_bola_aliada = 10'd105;
      raio_bola_aliada = 10'd0;
      tick();
      tick();
      confere("r0_pontos", pontos, 16'h0002);
      reinicio = 1'b1;
      tick();
      reinicio = 1'b0;
      confere("reini_jogando", pontos, 16'h0002);
      x_bola_aliada = 10'd100;
      raio_bola_inimiga = 10'd5;
      tick();
      confere("ini1_pulso", {15'd0, acerto_inimigo}, 16'd1);
      confere("ini1_vidas", {14'd0, vidas}, 16'd2);
      raio_bola_inimiga = 10'd0;
      tick();
      tick();
      raio_bola_inimiga = 10'd5;
      tick();
      confere("imune_pulso", {15'd0, acerto_inimigo}, 16'd0);
      confere("imune_vidas", {14'd0, vidas}, 16'd2);
      raio_bola_inimiga = 10'd0;
      repeat (20) tick();
      raio_bola_inimiga = 10'd5;
      tick();
      confere("ini2_vidas", {14'd0, vidas}, 16'd1);
      raio_bola_inimiga = 10'd0;
      repeat (20) tick();
      raio_bola_inimiga = 10'd5;
      raio_bola_aliada = 10'd5;
      tick();
      confere("fim_vidas", {14'd0, vidas}, 16'd0);
      confere("fim_perdeu", {15'd0, perdeu}, 16'd1);
      confere("fim_pontos", pontos, 16'h0003);
      confere("fim_ali", {15'd0, acerto_aliado}, 16'd1);
      raio_bola_inimiga = 10'd0;
      raio_bola_aliada = 10'd0;
      tick();
      raio_bola_aliada = 10'd5;
      pausa = 1'b1;
      tick();
      confere("perdeu_ali", {15'd0, acerto_aliado}, 16'd0);
      confere("perdeu_pausa", {15'd0, perdeu}, 16'd1);
      confere("perdeu_pontos", pontos, 16'h0003);
      raio_bola_aliada = 10'd0;
      pausa = 1'b0;
      tick();
      reinicio = 1'b1;
      tick();
      reinicio = 1'b0;
      confere("reini_perdeu", {15'd0, perdeu}, 16'd0);
      confere("reini_pontos", pontos, 16'h0000);
      confere("reini_vidas", {14'd0, vidas}, 16'd3);
      tick();
      confere("reini_hex5", {9'd0, HEX5}, 16'h30);
      pausa = 1'b1;
      tick();
      tick();
      raio_bola_aliada = 10'd5;
      raio_bola_inimiga = 10'd5;
      tick();
      tick();
      pausa = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (acerto_aliado || acerto_inimigo) n++;
      end
      confere("pausa_pulsos", 16'(n), 16'd0);
      confere("pausa_pontos", pontos, 16'h0000);
      confere("pausa_vidas", {14'd0, vidas}, 16'd3);
      raio_bola_aliada = 10'd0;
      raio_bola_inimiga = 10'd0;
      tick();
      for (int i = 1; i <= 9999; i++) begin
         raio_bola_aliada = 10'd5;
         tick();
         raio_bola_aliada = 10'd0;
         tick();
         if (i == 10 || i == 100 || i == 1000 || i == 5678 || i == 9999)
            confere($sformatf("sat_%0d", i), pontos, to_bcd(i));
      end
      raio_bola_aliada = 10'd5;
      tick();
      confere("sat_pontos", pontos, 16'h9999);
      raio_bola_aliada = 10'd0;
      tick();
      confere("sat_hex3", {9'd0, HEX3}, 16'h10);
      raio_bola_inimiga = 10'd5;
      tick();
      confere("rimune_vidas", {14'd0, vidas}, 16'd2);
      raio_bola_inimiga = 10'd0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      confere("rmeio_pontos", pontos, 16'h0000);
      confere("rmeio_vidas", {14'd0, vidas}, 16'd3);
      confere("rmeio_perdeu", {15'd0, perdeu}, 16'd0);
      confere("rmeio_pulso", {15'd0, acerto_inimigo}, 16'd0);
      reset = 1'b1;
      tick();
      confere("rmeio_hex3", {9'd0, HEX3}, 16'h40);
      confere("rmeio_hex5", {9'd0, HEX5}, 16'h30);
      raio_bola_inimiga = 10'd5;
      tick();
      confere("pos_rst_vidas", {14'd0, vidas}, 16'd2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
